// File: rtl/uart_rx_deserializer.sv
// UART receive framing engine: start/data/stop tracking with mid-bit sampling.
// Delivers good words with a one-cycle valid pulse and flags bad stop bits.
module uart_rx_deserializer #(
   parameter int CLOCKS_PER_BIT = 8,
   parameter int DATA_BITS      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in_synced,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 busy
);

   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        clk_cnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 ferr_q;
   logic                 busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!serial_in_synced) begin
                  state_q   <= START;
                  clk_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt_q == HALF) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  if (!serial_in_synced) begin
                     state_q <= DATA;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (clk_cnt_q == FULL) begin
                  clk_cnt_q <= '0;
                  shift_q   <= {serial_in_synced,
                                shift_q[DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + BW'(1);
                  if (bit_cnt_q == LAST) begin
                     state_q <= STOP;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            STOP: begin
               if (clk_cnt_q == FULL) begin
                  clk_cnt_q <= '0;
                  if (serial_in_synced) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= BRK;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            BRK: begin
               // hold until the line recovers so a stuck-low line cannot re-frame
               if (serial_in_synced) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out      = data_q;
   assign data_valid    = valid_q;
   assign framing_error = ferr_q;
   assign busy          = busy_q;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side framing engine of the UART. Consumes the 3-FF-synchronized serial line and tracks one frame at a time: start bit, DATA_BITS data bits LSB first, one stop bit. Samples each bit at its midpoint using a CLOCKS_PER_BIT counter. Delivers each good byte with a one-cycle valid pulse and flags bad stop bits. Sits directly downstream of the synchronizer and upstream of the Rx byte consumer.

## Interface
- CLOCKS_PER_BIT, 8, system clocks per UART bit; even, ≥4.
- DATA_BITS, 8, data bits per frame; 5..8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- serial_in_synced  in  1  synchronized line; idle high.
- data_out  out  DATA_BITS  last correctly framed word; holds until the next good frame.
- data_valid  out  1  one-cycle pulse; data_out is new this cycle.
- framing_error  out  1  one-cycle pulse; stop bit sampled low.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- One clock and one reset. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - bit counter = 0; clock counter = 0
  - shift register = 0
  - data_out = 0, data_valid = 0, framing_error = 0, busy = 0
- Asserting reset mid-frame aborts the frame. No data_valid or framing_error pulse results.
- States:
  - IDLE: when serial_in_synced == 0, go to START and clear the clock counter.
  - START: count to CLOCKS_PER_BIT/2−1, then sample the line.
    - Line 0: go to DATA; clear clock counter and bit counter.
    - Line 1: glitch; go to IDLE with no output pulse.
  - DATA: count to CLOCKS_PER_BIT−1, then sample.
    - Shift the sample in at the MSB and shift right, so bit 0 ends at the LSB.
    - Increment the bit counter.
    - After DATA_BITS samples, go to STOP.
  - STOP: count to CLOCKS_PER_BIT−1, then sample.
    - Line 1: data_out ← shift register; pulse data_valid; go to IDLE.
    - Line 0: pulse framing_error; data_out unchanged; go to BREAK.
  - BREAK: stay until serial_in_synced == 1, then go to IDLE. A line held low produces no repeated frames.
- The return to IDLE happens at mid-stop-bit. A start edge arriving half a bit later is caught, so back-to-back frames need no extra idle time.
- data_valid and framing_error are never high in the same cycle.
- Neither data_valid nor framing_error ever lasts more than one cycle.
- If serial_in_synced is low when reset deasserts, IDLE starts a frame on the first cycle. This is the expected behaviour.
- Counter widths: $clog2(CLOCKS_PER_BIT) for the clock counter and $clog2(DATA_BITS+1) for the bit counter. No wrap inside a frame.

## Timing
- Define T0 as the clock edge at which IDLE first sees serial_in_synced == 0.
- Sample edges:
  - start bit: T0 + CLOCKS_PER_BIT/2
  - data bit i: T0 + CLOCKS_PER_BIT/2 + (i+1)·CLOCKS_PER_BIT
  - stop bit: T0 + CLOCKS_PER_BIT/2 + (DATA_BITS+1)·CLOCKS_PER_BIT
- data_valid or framing_error is high for exactly the cycle following the stop-bit sample edge.
- Worked values for defaults: start T0+4, bit0 T0+12, bit7 T0+68, stop T0+76. Pulse asserted after edge T0+76; low again after T0+77.
- busy:
  - rises after T0
  - falls on the same edge that asserts data_valid
  - on a framing error, falls on the edge after BREAK sees the line high
- End-to-end latency from the raw pin = the synchronizer's 3 cycles + the above.

## Test plan
- Byte 0x55, CLOCKS_PER_BIT=8, line idle before and after.
  - data_valid high for 1 cycle, 77 cycles after T0.
  - data_out = 0x55; framing_error never high.
- Frames 0xA3 then 0x0F, second start bit immediately after first stop bit.
  - Two data_valid pulses exactly 80 cycles apart.
  - data_out = 0xA3, then 0x0F.
- Line low for 2 cycles, then high.
  - busy pulses for ≤4 cycles and returns to IDLE.
  - No data_valid or framing_error pulse.
- Byte 0xFF with stop bit driven 0, line held low for 30 more cycles, then high.
  - One framing_error pulse; data_out keeps its previous value.
  - Stays in BREAK with no new frame while low; busy drops after the line goes high.
- reset asserted for one cycle at T0+40 during byte 0x3C.
  - All outputs 0 next cycle; no pulses.
  - A following 0x3C frame is received correctly.
- DATA_BITS=5, byte 0x1A.
  - data_out = 5'h1A; data_valid 53 cycles after T0.
